dtc_stub_router: RTL and testbench
==================================

# dtc_stub_router

Parametrised stub router for the DTC receive path. Accepts one deserialised CIC frame per handshake and unpacks NSTUBS fixed-width stubs, one per clock. It routes each stub by its chip-ID field to a per-chip write port with its own address pointer, in wrap or saturate mode. It replaces the fixed 10-stub, 8-chip, 21-bit case logic that drove the per-MPA BRAMs.

## Interface
- FRAME_W, 256: input frame width
- HDR_W, 26: header bits at the MSB end of the frame, discarded
- STUB_W, 21: stub width
- NSTUBS, 10: stubs per frame; requires HDR_W + NSTUBS*STUB_W <= FRAME_W
- CHIP_LSB, 15: bit offset of the chip-ID field inside a stub
- CHIP_W, 3: chip-ID field width
- NCHIPS, 8: number of output channels; 1..2^CHIP_W
- ADDR_W, 7: per-channel address width; depth = 2^ADDR_W
- WRAP, 1: 1 = pointers wrap; 0 = pointers saturate and drop on full
- SKIP_NULL, 1: 1 = all-zero stubs are not written
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  frame valid
- in_ready  out  1  router can accept a frame
- in_frame  in  FRAME_W  frame; stub k = in_frame[FRAME_W-HDR_W-1-k*STUB_W -: STUB_W]
- clear  in  1  synchronous clear of pointers, fills, flags and counters
- wr_en  out  NCHIPS  per-channel write strobe
- wr_addr  out  NCHIPS*ADDR_W  per-channel write address; channel c at [c*ADDR_W +: ADDR_W]
- wr_data  out  NCHIPS*STUB_W  per-channel write data; same packing as wr_addr
- fill  out  NCHIPS*(ADDR_W+1)  per-channel entries written since reset/clear
- ovf  out  NCHIPS  sticky overflow per channel
- bad_id_cnt  out  16  stubs dropped for chip ID >= NCHIPS; saturating
- frame_done  out  1  one-cycle pulse with the last stub of a frame

## Operation
- States are IDLE and EXTRACT. in_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE: on in_valid && in_ready, latch in_frame, set idx = 0, go to EXTRACT.
- EXTRACT: each edge processes stub idx and increments idx. After stub NSTUBS-1 is processed, go to IDLE and register frame_done = 1.
- Chip ID = stub[CHIP_LSB +: CHIP_W].
- A stub is dropped, with no strobe, in any of these cases:
  - SKIP_NULL = 1 and the stub is all zeros. No counter changes.
  - Chip ID >= NCHIPS. bad_id_cnt increments, saturating at 16'hFFFF.
  - WRAP = 0 and fill[c] == 2^ADDR_W. ovf[c] is set.
- Otherwise, for channel c:
  - wr_en[c] = 1, wr_addr[c] = ptr[c], wr_data[c] = the stub.
  - ptr[c] increments modulo 2^ADDR_W.
  - fill[c] increments, saturating at 2^ADDR_W.
  - WRAP = 1 and ptr[c] wrapping from 2^ADDR_W-1 to 0 sets ovf[c].
- At most one wr_en bit is high in any cycle. wr_addr and wr_data hold their values when wr_en is low.
- clear = 1 at an edge:
  - ptr, fill, ovf and bad_id_cnt go to 0.
  - The stub scheduled for that edge is discarded: no strobe, no counters.
  - The FSM is unaffected; extraction continues with the next stub on pointers starting at 0.
  - clear in IDLE together with in_valid still accepts the frame.
- Reset values: state IDLE, in_ready 1, wr_en 0, wr_addr 0, wr_data 0, fill 0, ovf 0, bad_id_cnt 0, frame_done 0.
- rst_n asserted mid-frame abandons the frame; no further strobes.

## Timing
- Acceptance edge E0. Stub k's strobe, address and data are registered at edge E0+1+k and are valid for the following cycle; BRAM samples them at edge E0+2+k.
- frame_done is high in the same cycle as stub NSTUBS-1's strobe, including when that stub is dropped.
- in_ready is low for the NSTUBS cycles after E0 and high again in the frame_done cycle. Minimum frame period is NSTUBS+1 cycles.
- in_frame need only be stable at E0.
- Throughput limit is one stub per clock.

## Test plan
- Defaults, one frame with stubs k = 0..9 each carrying chip ID k%8 and payload 21'h1000+k -> wr_en[k%8] at E0+1+k; chips 0 and 1 are written at addresses 0 then 1; frame_done with k=9; fill = {2,2,1,1,1,1,1,1}.
- 13 frames with every stub on chip 3, WRAP=1 -> wr_addr[3] runs 0..127 then 0..1 (130 writes); ovf[3] sets at the wrap; fill[3] = 128.
- Same stimulus with WRAP=0 -> 128 writes, then no strobes; ovf[3] = 1; other channels untouched.
- NCHIPS=6, stub with chip ID 7, plus an all-zero stub -> no strobes; bad_id_cnt = 1; pointers unchanged.
- clear pulsed at E0+4 -> stub 3 is not written, stub 4 is written at address 0, fill restarts from 0.
- rst_n low at E0+5 -> outputs go to reset values immediately; in_valid held -> next frame accepted at the first edge after release.

Source files
------------

// File: rtl/dtc_stub_router.sv
// Stub router for the DTC receive path: unpacks NSTUBS stubs from one CIC frame, one per clock,
// and routes each to a per-chip write port with its own wrapping or saturating address pointer.
module dtc_stub_router #(
    parameter int unsigned FRAME_W   = 256,
    parameter int unsigned HDR_W     = 26,
    parameter int unsigned STUB_W    = 21,
    parameter int unsigned NSTUBS    = 10,
    parameter int unsigned CHIP_LSB  = 15,
    parameter int unsigned CHIP_W    = 3,
    parameter int unsigned NCHIPS    = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned SKIP_NULL = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FRAME_W-1:0]           in_frame_i,
    input  logic                         clear_i,
    output logic [NCHIPS-1:0]            wr_en_o,
    output logic [NCHIPS*ADDR_W-1:0]     wr_addr_o,
    output logic [NCHIPS*STUB_W-1:0]     wr_data_o,
    output logic [NCHIPS*(ADDR_W+1)-1:0] fill_o,
    output logic [NCHIPS-1:0]            ovf_o,
    output logic [15:0]                  bad_id_cnt_o,
    output logic                         frame_done_o
);
    localparam int unsigned PAY_W = NSTUBS * STUB_W;
    localparam int unsigned IDX_W = (NSTUBS > 1) ? $clog2(NSTUBS) : 1;
    localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {StIdle, StExtract} state_e;

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [PAY_W-1:0]              stubs_q, stubs_d;
    logic [NCHIPS-1:0][ADDR_W-1:0] ptr_q, ptr_d;
    logic [NCHIPS-1:0][ADDR_W:0]   fill_q, fill_d;
    logic [NCHIPS-1:0]             ovf_q, ovf_d;
    logic [15:0]                   bad_q, bad_d;
    logic [NCHIPS-1:0]             wr_en_q, wr_en_d;
    logic [NCHIPS-1:0][ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [NCHIPS-1:0][STUB_W-1:0] wr_data_q, wr_data_d;
    logic                          done_q, done_d;

    logic [STUB_W-1:0] stub;
    logic [CHIP_W-1:0] chip;
    logic              unused_frame;

    // Payload is shifted up one stub per cycle, so the current stub is always at the top.
    assign stub         = stubs_q[PAY_W-1 -: STUB_W];
    assign chip         = stub[CHIP_LSB +: CHIP_W];
    assign unused_frame = ^in_frame_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stubs_d   = stubs_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        ovf_d     = ovf_q;
        bad_d     = bad_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    stubs_d = in_frame_i[FRAME_W-HDR_W-1 -: PAY_W];
                    idx_d   = '0;
                    state_d = StExtract;
                end
            end
            StExtract: begin
                stubs_d = stubs_q << STUB_W;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NSTUBS - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                if (!clear_i && !((SKIP_NULL != 0) && (stub == '0))) begin
                    if (32'(chip) >= NCHIPS) begin
                        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
                    end else begin
                        for (int unsigned c = 0; c < NCHIPS; c++) begin
                            if (32'(chip) == c) begin
                                if ((WRAP == 0) && (fill_q[c] == FILL_MAX)) begin
                                    ovf_d[c] = 1'b1;
                                end else begin
                                    wr_en_d[c]   = 1'b1;
                                    wr_addr_d[c] = ptr_q[c];
                                    wr_data_d[c] = stub;
                                    ptr_d[c]     = ptr_q[c] + 1'b1;
                                    if (fill_q[c] != FILL_MAX) fill_d[c] = fill_q[c] + 1'b1;
                                    if ((WRAP != 0) && (ptr_q[c] == '1)) ovf_d[c] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // The stub on a clear edge was already suppressed above; only bookkeeping resets here.
        if (clear_i) begin
            ptr_d  = '0;
            fill_d = '0;
            ovf_d  = '0;
            bad_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            stubs_q   <= '0;
            ptr_q     <= '0;
            fill_q    <= '0;
            ovf_q     <= '0;
            bad_q     <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stubs_q   <= stubs_d;
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign in_ready_o   = (state_q == StIdle);
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign fill_o       = fill_q;
    assign ovf_o        = ovf_q;
    assign bad_id_cnt_o = bad_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_dtc_stub_router.sv
// Bench for dtc_stub_router: three configurations (default, saturating, 6 chips) share stimulus
// and are compared every stub cycle against a per-channel reference model.
module tb_dtc_stub_router;
    typedef logic [20:0] stubs_t [10];

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] in_frame;
    logic         clear;

    logic         in_ready_a, in_ready_b, in_ready_c;
    logic         frame_done_a, frame_done_b, frame_done_c;
    logic [7:0]   wr_en_a, wr_en_b, ovf_a, ovf_b;
    logic [5:0]   wr_en_c, ovf_c;
    logic [55:0]  wr_addr_a, wr_addr_b;
    logic [41:0]  wr_addr_c;
    logic [167:0] wr_data_a, wr_data_b;
    logic [125:0] wr_data_c;
    logic [63:0]  fill_a, fill_b;
    logic [47:0]  fill_c;
    logic [15:0]  bad_a, bad_b, bad_c;

    int checks = 0;
    int failures = 0;
    int n_wr_a3, n_wr_b3, n_wr_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dtc_stub_router u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .in_frame_i(in_frame), .clear_i(clear), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a),
        .wr_data_o(wr_data_a), .fill_o(fill_a), .ovf_o(ovf_a), .bad_id_cnt_o(bad_a),
        .frame_done_o(frame_done_a)
    );
    dtc_stub_router #(.WRAP(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .in_frame_i(in_frame), .clear_i(clear), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b),
        .wr_data_o(wr_data_b), .fill_o(fill_b), .ovf_o(ovf_b), .bad_id_cnt_o(bad_b),
        .frame_done_o(frame_done_b)
    );
    dtc_stub_router #(.NCHIPS(6)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_c),
        .in_frame_i(in_frame), .clear_i(clear), .wr_en_o(wr_en_c), .wr_addr_o(wr_addr_c),
        .wr_data_o(wr_data_c), .fill_o(fill_c), .ovf_o(ovf_c), .bad_id_cnt_o(bad_c),
        .frame_done_o(frame_done_c)
    );

    // Observed outputs widened to 8 channels; the 6-chip instance pads with zeros.
    logic [7:0]   o_en [3];
    logic [55:0]  o_addr [3];
    logic [167:0] o_data [3];
    logic [63:0]  o_fill [3];
    logic [7:0]   o_ovf [3];
    logic [15:0]  o_bad [3];
    logic         o_done [3];
    logic         o_rdy [3];
    assign o_en[0] = wr_en_a;     assign o_en[1] = wr_en_b;     assign o_en[2] = {2'b0, wr_en_c};
    assign o_addr[0] = wr_addr_a; assign o_addr[1] = wr_addr_b; assign o_addr[2] = {14'b0, wr_addr_c};
    assign o_data[0] = wr_data_a; assign o_data[1] = wr_data_b; assign o_data[2] = {42'b0, wr_data_c};
    assign o_fill[0] = fill_a;    assign o_fill[1] = fill_b;    assign o_fill[2] = {16'b0, fill_c};
    assign o_ovf[0] = ovf_a;      assign o_ovf[1] = ovf_b;      assign o_ovf[2] = {2'b0, ovf_c};
    assign o_bad[0] = bad_a;      assign o_bad[1] = bad_b;      assign o_bad[2] = bad_c;
    assign o_done[0] = frame_done_a; assign o_done[1] = frame_done_b; assign o_done[2] = frame_done_c;
    assign o_rdy[0] = in_ready_a;    assign o_rdy[1] = in_ready_b;    assign o_rdy[2] = in_ready_c;

    // Reference model: per-instance channel state tracked as plain integers.
    int         nch [3] = '{8, 8, 6};
    bit         wrp [3] = '{1'b1, 1'b0, 1'b1};
    int         m_ptr [3][8];
    int         m_fill [3][8];
    bit         m_ovf [3][8];
    int         m_bad [3];
    bit         e_en [3][8];
    logic [6:0] e_addr [3][8];
    logic [20:0] e_data [3][8];
    stubs_t     cur;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_bad[i] = 0;
            for (int c = 0; c < 8; c++) begin
                m_ptr[i][c] = 0; m_fill[i][c] = 0; m_ovf[i][c] = 1'b0; e_en[i][c] = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        model_clear();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 8; c++) begin e_addr[i][c] = '0; e_data[i][c] = '0; end
    endfunction

    function automatic void model_stub(input int i, input logic [20:0] s);
        int ch;
        ch = int'(s[17:15]);
        for (int c = 0; c < 8; c++) e_en[i][c] = 1'b0;
        if (s == 21'd0) return;
        if (ch >= nch[i]) begin
            if (m_bad[i] < 65535) m_bad[i]++;
            return;
        end
        if (!wrp[i] && m_fill[i][ch] == 128) begin
            m_ovf[i][ch] = 1'b1;
            return;
        end
        e_en[i][ch] = 1'b1;
        e_addr[i][ch] = 7'(m_ptr[i][ch]);
        e_data[i][ch] = s;
        if (wrp[i] && m_ptr[i][ch] == 127) m_ovf[i][ch] = 1'b1;
        m_ptr[i][ch] = (m_ptr[i][ch] + 1) % 128;
        if (m_fill[i][ch] < 128) m_fill[i][ch]++;
    endfunction

    function automatic logic [7:0] ev_en(input int i);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = e_en[i][c];
        return v;
    endfunction
    function automatic logic [55:0] ev_addr(input int i);
        logic [55:0] v;
        for (int c = 0; c < 8; c++) v[c*7 +: 7] = e_addr[i][c];
        return v;
    endfunction
    function automatic logic [167:0] ev_data(input int i);
        logic [167:0] v;
        for (int c = 0; c < 8; c++) v[c*21 +: 21] = e_data[i][c];
        return v;
    endfunction
    function automatic logic [63:0] ev_fill(input int i);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(m_fill[i][c]);
        return v;
    endfunction
    function automatic logic [7:0] ev_ovf(input int i);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = m_ovf[i][c];
        return v;
    endfunction

    function automatic logic [255:0] make_frame(input stubs_t s);
        logic [255:0] f;
        for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom;
        for (int k = 0; k < 10; k++) f[229 - k*21 -: 21] = s[k];
        return f;
    endfunction

    function automatic logic [20:0] rand_stub();
        if ($urandom_range(0, 7) == 0) return 21'd0;
        return 21'($urandom);
    endfunction

    // Present a frame and consume the acceptance edge; in_frame is scrambled afterwards.
    task automatic accept(input stubs_t s, input bit clr);
        cur = s;
        in_frame = make_frame(s);
        in_valid = 1'b1;
        clear = clr;
        @(posedge clk);
        for (int i = 0; i < 3; i++) for (int c = 0; c < 8; c++) e_en[i][c] = 1'b0;
        if (clr) model_clear();
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        in_frame = {8{$urandom}};
        checks++;
        if (in_ready_a !== 1'b0 || wr_en_a !== 8'd0 || frame_done_a !== 1'b0) begin
            failures++;
            $display("FAIL accept rdy=%b en=%h done=%b, want 0/00/0", in_ready_a, wr_en_a,
                     frame_done_a);
        end
    endtask

    // One extraction edge for stub k, compared against the model on all instances.
    task automatic step(input int k, input bit clr);
        clear = clr;
        @(posedge clk);
        if (clr) model_clear();
        else for (int i = 0; i < 3; i++) model_stub(i, cur[k]);
        #1;
        clear = 1'b0;
        if (wr_en_a[3]) n_wr_a3++;
        if (wr_en_b[3]) n_wr_b3++;
        if (wr_en_c != 6'd0) n_wr_c++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_en[i] !== ev_en(i) || o_addr[i] !== ev_addr(i) || o_data[i] !== ev_data(i) ||
                o_fill[i] !== ev_fill(i) || o_ovf[i] !== ev_ovf(i) ||
                o_bad[i] !== 16'(m_bad[i]) || o_done[i] !== (k == 9) || o_rdy[i] !== (k == 9)) begin
                failures++;
                $display("FAIL step inst=%0d k=%0d en=%h want %h addr=%h want %h data=%h want %h fill=%h want %h ovf=%h want %h bad=%0d want %0d done=%b rdy=%b want %b",
                         i, k, o_en[i], ev_en(i), o_addr[i], ev_addr(i), o_data[i], ev_data(i),
                         o_fill[i], ev_fill(i), o_ovf[i], ev_ovf(i), o_bad[i], m_bad[i],
                         o_done[i], o_rdy[i], (k == 9));
            end
        end
    endtask

    task automatic idle_clear();
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        clear = 1'b0;
        checks++;
        if (in_ready_a !== 1'b1 || fill_a !== 64'd0 || ovf_a !== 8'd0 || wr_en_a !== 8'd0) begin
            failures++;
            $display("FAIL idle_clear rdy=%b fill=%h ovf=%h en=%h", in_ready_a, fill_a, ovf_a,
                     wr_en_a);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_en[i] !== 0 || o_addr[i] !== 0 || o_data[i] !== 0 || o_fill[i] !== 0 ||
                o_ovf[i] !== 0 || o_bad[i] !== 0 || o_done[i] !== 0 || o_rdy[i] !== 1) begin
                failures++;
                $display("FAIL reset inst=%0d en=%h addr=%h fill=%h ovf=%h bad=%0d done=%b rdy=%b",
                         i, o_en[i], o_addr[i], o_fill[i], o_ovf[i], o_bad[i], o_done[i], o_rdy[i]);
            end
        end
    endtask

    task automatic test_basic();
        stubs_t s;
        for (int k = 0; k < 10; k++) s[k] = 21'((k % 8) << 15) | (21'h1000 + 21'(k));
        accept(s, 1'b0);
        for (int k = 0; k < 10; k++) step(k, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (fill_a[c*8 +: 8] !== ((c < 2) ? 8'd2 : 8'd1)) begin
                failures++;
                $display("FAIL basic_fill ch=%0d got %0d want %0d", c, fill_a[c*8 +: 8],
                         (c < 2) ? 2 : 1);
            end
        end
        checks++;
        if (bad_c !== 16'd2 || bad_a !== 16'd0) begin
            failures++;
            $display("FAIL basic_bad bad_c=%0d want 2 bad_a=%0d want 0", bad_c, bad_a);
        end
    endtask

    task automatic test_wrap();
        stubs_t s;
        idle_clear();
        n_wr_a3 = 0;
        n_wr_b3 = 0;
        for (int f = 0; f < 13; f++) begin
            for (int k = 0; k < 10; k++) begin
                s[k] = 21'($urandom);
                s[k][17:15] = 3'd3;
            end
            accept(s, 1'b0);
            for (int k = 0; k < 10; k++) step(k, 1'b0);
        end
        checks++;
        if (n_wr_a3 !== 130 || fill_a[31:24] !== 8'd128 || ovf_a !== 8'h08 ||
            wr_addr_a[27:21] !== 7'd1) begin
            failures++;
            $display("FAIL wrap writes=%0d want 130 fill=%0d want 128 ovf=%h want 08 addr=%0d want 1",
                     n_wr_a3, fill_a[31:24], ovf_a, wr_addr_a[27:21]);
        end
        checks++;
        if (n_wr_b3 !== 128 || fill_b !== {32'd0, 8'd128, 24'd0} || ovf_b !== 8'h08) begin
            failures++;
            $display("FAIL saturate writes=%0d want 128 fill=%h ovf=%h want 08", n_wr_b3, fill_b,
                     ovf_b);
        end
    endtask

    task automatic test_bad_id();
        stubs_t s;
        idle_clear();
        n_wr_c = 0;
        for (int k = 0; k < 10; k++) s[k] = 21'd0;
        s[0] = {3'b101, 3'd7, 15'h1234};
        accept(s, 1'b0);
        for (int k = 0; k < 10; k++) step(k, 1'b0);
        checks++;
        if (n_wr_c !== 0 || bad_c !== 16'd1 || fill_c !== 48'd0 || bad_a !== 16'd0 ||
            fill_a[63:56] !== 8'd1) begin
            failures++;
            $display("FAIL bad_id strobes=%0d want 0 bad_c=%0d want 1 fill_c=%h bad_a=%0d fill_a7=%0d",
                     n_wr_c, bad_c, fill_c, bad_a, fill_a[63:56]);
        end
    endtask

    task automatic test_clear();
        stubs_t s;
        for (int k = 0; k < 10; k++) begin
            s[k] = 21'($urandom);
            s[k][17:15] = 3'd1;
        end
        accept(s, 1'b1);
        for (int k = 0; k < 3; k++) step(k, 1'b0);
        step(3, 1'b1);
        step(4, 1'b0);
        checks++;
        if (wr_en_a !== 8'h02 || wr_addr_a[13:7] !== 7'd0 || fill_a[15:8] !== 8'd1) begin
            failures++;
            $display("FAIL clear_restart en=%h want 02 addr=%0d want 0 fill=%0d want 1", wr_en_a,
                     wr_addr_a[13:7], fill_a[15:8]);
        end
        for (int k = 5; k < 10; k++) step(k, 1'b0);
        checks++;
        if (fill_a[15:8] !== 8'd6) begin
            failures++;
            $display("FAIL clear_fill got %0d want 6", fill_a[15:8]);
        end
    endtask

    task automatic test_back_to_back();
        stubs_t s;
        int clr_k;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 10; k++) s[k] = rand_stub();
            clr_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            accept(s, ($urandom_range(0, 7) == 0));
            for (int k = 0; k < 10; k++) step(k, (k == clr_k));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_fill[i] !== ev_fill(i) || o_bad[i] !== 16'(m_bad[i])) begin
                failures++;
                $display("FAIL random_end inst=%0d fill=%h want %h bad=%0d want %0d", i, o_fill[i],
                         ev_fill(i), o_bad[i], m_bad[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        stubs_t s, s2;
        for (int k = 0; k < 10; k++) begin
            s[k] = rand_stub();
            s2[k] = rand_stub();
        end
        accept(s, 1'b0);
        for (int k = 0; k < 4; k++) step(k, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_frame = make_frame(s2);
        cur = s2;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_en[i] !== 0 || o_addr[i] !== 0 || o_data[i] !== 0 || o_fill[i] !== 0 ||
                o_ovf[i] !== 0 || o_bad[i] !== 0 || o_done[i] !== 0 || o_rdy[i] !== 1) begin
                failures++;
                $display("FAIL reset_mid inst=%0d en=%h addr=%h fill=%h bad=%0d rdy=%b", i,
                         o_en[i], o_addr[i], o_fill[i], o_bad[i], o_rdy[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ((wr_en_a | wr_en_b) !== 8'd0 || wr_en_c !== 6'd0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold en=%h/%h/%h rdy=%b", wr_en_a, wr_en_b, wr_en_c, in_ready_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_accept rdy=%b want 0", in_ready_a);
        end
        for (int k = 0; k < 10; k++) step(k, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_frame = '0;
        clear = 1'b0;
        n_wr_a3 = 0;
        n_wr_b3 = 0;
        n_wr_c = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_id();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
